lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Load/store unit between the execute stage and the word-only data memory (dm).
//  - Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  - Does sign/zero extension on loads.
//  - Implements byte/half stores as a 2-cycle read-modify-write, because dm has no byte enables.
//  - Flags misaligned, illegal-funct3 and out-of-range accesses.
// PARAMETERS
//  DM_DEPTH     64  words in dm; a word index >= DM_DEPTH is out of range
//  CHECK_RANGE  1   1: out-of-range access is an error; 0: no range check
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  req_valid      in   1   core presents an access
//  req_ready      out  1   LSU accepts; a request transfers when valid && ready
//  req_we         in   1   1 = store, 0 = load
//  req_funct3     in   3   RV32I funct3 (size/sign)
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-justified
//  resp_valid     out  1   one-cycle pulse: access complete
//  resp_rdata     out  32  extended load data; 0 for stores and errors
//  resp_err       out  1   qualifies resp_valid: access was rejected
//  dm_mem_write   out  1   dm write enable
//  dm_addr        out  32  dm address, always {addr[31:2],2'b00}
//  dm_wdata       out  32  dm write data
//  dm_rdata       in   32  dm combinational read data
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; merge/addr regs=0.
//   Combinational outputs follow the reset state: dm_mem_write=0, req_ready=1.
//  States: IDLE, RMW_WR.
//   req_ready=1 only in IDLE.
//   dm_mem_write is decoded from state and the current request only; it is never registered.
//  Error check on accept, in this priority:
//   1. illegal funct3: loads 3/6/7, stores 3..7
//   2. misaligned: half with addr[0]=1; word with addr[1:0]!=0
//   3. out of range (only when CHECK_RANGE=1): addr[31:2] >= DM_DEPTH
//   On error: no dm write; next cycle resp_valid=1, resp_err=1, resp_rdata=0.
//  Load (IDLE):
//   - dm_addr from req_addr.
//   - Select byte/half lane addr[1:0] from dm_rdata; sign-extend (LB/LH) or zero-extend (LBU/LHU).
//   - Register the result: resp_valid the next cycle (latency 1). Stay in IDLE, so back-to-back loads run every cycle.
//  SW (IDLE): dm_mem_write=1, dm_wdata=req_wdata in the accept cycle.
//   Next cycle: resp_valid=1, resp_rdata=0. Latency 1.
//  SB/SH (IDLE, accept cycle):
//   - Read the old word.
//   - Merge req_wdata[7:0]/[15:0] into lane addr[1:0] and register it in merged_q.
//   - Register the word address in addr_q. Go to RMW_WR.
//  RMW_WR (1 cycle):
//   - dm_mem_write=1, dm_addr=addr_q, dm_wdata=merged_q, req_ready=0.
//   - Go to IDLE; resp_valid the next cycle. Latency 2.
//  resp_valid: high exactly 1 cycle per accepted request.
//   resp_rdata/resp_err hold their value until the next response.
//  No request (IDLE, !req_valid): dm_addr still follows req_addr, dm_mem_write=0, no response.
//  Reset asserted in RMW_WR: the pending write is dropped. dm_mem_write falls asynchronously with rst_n and no partial write reaches dm.
//  Load that follows a store: it reads the already-written word. The write commits at the edge that ends the store's last dm cycle, so dm supplies the forwarding and the LSU adds none.
// STRUCTURE
//  lsu_pkg:
//   - funct3 localparams F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5, F3_SB=0, F3_SH=1, F3_SW=2.
//   - State encoding IDLE=1'b0, RMW_WR=1'b1.
//  Sub-module lsu_align (combinational):
//   - load lane extract/extend.
//   - store lane merge.
//   - error decode.
//  Top level holds the FSM, the response registers and the dm muxing.
// TESTING (bench includes a dm model with combinational read and posedge write)
//  1. Reset: rst_n=0 mid-run -> resp_valid=0, dm_mem_write=0, req_ready=1 at once.
//  2. SW 0x12345678 @0x10, then LW @0x10 -> 1-cycle store response, then rdata=0x12345678, err=0.
//  3. Word @0x20 = 0x80FF7F01:
//     LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
//  4. Word @0x20 = 0xAABBCCDD:
//     SB 0x11 @0x21 -> req_ready=0 for one cycle, dm holds 0xAABB11DD, response 2 cycles after accept.
//     Then SH 0x2233 @0x22 -> 0x223311DD.
//  5. Errors -> resp_err=1, dm unchanged, 1-cycle latency:
//     LW @0x06; SH @0x05; funct3=3 load; LW @0x100 with DM_DEPTH=64.
//  6. Back-to-back: 4 loads on consecutive cycles, then SB, then LW of the same word.
//     Loads respond every cycle; the LW sees the merged byte; the SB-accept cycle is followed by exactly 1 stall cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding and the word-address helper.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: load lane extract/extend, byte/half
// store merge into the old word, and request error decode.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DM_DEPTH    = 64,
    parameter int CHECK_RANGE = 1
) (
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [31:0] merged,
    output logic        err
);

    localparam logic [29:0] DEPTH_W = 30'(DM_DEPTH);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic        range_err_s;

    // Load: pick the addressed lane and sign- or zero-extend it
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr[1:0])
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'h00_0000, byte_s};
            F3_LHU:  load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store: overlay the new byte/half onto the word just read from dm
    always_comb begin
        merged = rdata;
        case (funct3)
            F3_SB: begin
                case (addr[1:0])
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    2'd3:    merged[31:24] = wdata[7:0];
                    default: merged        = rdata;
                endcase
            end
            F3_SH: begin
                if (addr[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = rdata;
        endcase
    end

    // Error decode; any of the three classes rejects the access
    always_comb begin
        if (we) begin
            illegal_s = (funct3 > F3_SW);
        end else begin
            illegal_s = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
        end
        case (funct3[1:0])
            2'd1:    misaligned_s = addr[0];
            2'd2:    misaligned_s = (addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        range_err_s = (CHECK_RANGE != 0) && (addr[31:2] >= DEPTH_W);
        err = illegal_s || misaligned_s || range_err_s;
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit between execute and a word-only data memory; byte/half
// stores are done as a read-modify-write over two dm cycles.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DM_DEPTH    = 64,
    parameter int CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_mem_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    lsu_state_e  state_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic [31:0] merged_r;
    logic [31:0] addr_r;

    logic [31:0] load_data_s;
    logic [31:0] merged_s;
    logic        err_s;
    logic        accept_s;
    logic        is_sw_s;

    lsu_align #(
        .DM_DEPTH    (DM_DEPTH),
        .CHECK_RANGE (CHECK_RANGE)
    ) u_align (
        .funct3    (req_funct3),
        .we        (req_we),
        .addr      (req_addr),
        .wdata     (req_wdata),
        .rdata     (dm_rdata),
        .load_data (load_data_s),
        .merged    (merged_s),
        .err       (err_s)
    );

    // Request handshake and dm port muxing; the write strobe is gated by
    // rst_n so a pending write vanishes the instant reset asserts
    always_comb begin
        accept_s  = req_valid && (state_r == IDLE);
        is_sw_s   = req_we && (req_funct3 == F3_SW);
        req_ready = (state_r == IDLE);
        if (state_r == RMW_WR) begin
            dm_addr      = addr_r;
            dm_wdata     = merged_r;
            dm_mem_write = rst_n;
        end else begin
            dm_addr      = word_addr(req_addr);
            dm_wdata     = req_wdata;
            dm_mem_write = rst_n && accept_s && is_sw_s && !err_s;
        end
    end

    // FSM and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            merged_r     <= 32'h0000_0000;
            addr_r       <= 32'h0000_0000;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (err_s) begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                            resp_err_r   <= 1'b1;
                        end else if (!req_we) begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_data_s;
                            resp_err_r   <= 1'b0;
                        end else if (is_sw_s) begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                            resp_err_r   <= 1'b0;
                        end else begin
                            merged_r <= merged_s;
                            addr_r   <= word_addr(req_addr);
                            state_r  <= RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                    state_r      <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage with a 64-word dm model (combinational
// read, posedge write); expected responses carry their due cycle.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_mem_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] dm_mem [0:63];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks;
    int errors;
    int cyc;
    int acc;
    int acc_sb;

    lsu_mem_stage #(.DM_DEPTH(64), .CHECK_RANGE(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_mem_write (dm_mem_write),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dm model: single writer for both DUT writes and bench preloads
    assign dm_rdata = dm_mem[dm_addr[7:2]];
    always @(posedge clk) begin
        if (dm_mem_write) dm_mem[dm_addr[7:2]] <= dm_wdata;
        else if (pre_en)  dm_mem[pre_idx] <= pre_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every response must match the oldest expectation, on time
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got response at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input bit push, output int acc_cyc);
        int n;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected 1", n);
        end
        acc_cyc = cyc;
        if (push) begin
            e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        pre_en = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
        for (int i = 0; i < 64; i++) dm_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_dm_write", {31'd0, dm_mem_write}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW then LW of the same word
        issue(1'b1, 3'd2, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1, 1'b1, acc);
        drain();

        // load lane extraction and extension
        preload(6'd8, 32'h80FF_7F01);
        issue(1'b0, 3'd0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd4, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd5, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 1, 1'b1, acc);
        drain();

        // read-modify-write byte and half stores
        preload(6'd8, 32'hAABB_CCDD);
        issue(1'b1, 3'd0, 32'h21, 32'h0000_0011, 32'h0, 1'b0, 2, 1'b1, acc);
        check("sb_stall_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("sb_dm_word", dm_mem[8], 32'hAABB_11DD);
        issue(1'b1, 3'd1, 32'h22, 32'h0000_2233, 32'h0, 1'b0, 2, 1'b1, acc);
        drain();
        check("sh_dm_word", dm_mem[8], 32'h2233_11DD);

        // rejected accesses
        preload(6'd1, 32'hCAFE_F00D);
        issue(1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b1, 3'd1, 32'h05, 32'h0000_BEEF, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b1, 3'd5, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1, acc);
        drain();
        check("err_dm_word1", dm_mem[1], 32'hCAFE_F00D);
        check("err_dm_word4", dm_mem[4], 32'h1234_5678);
        check("err_dm_word0", dm_mem[0], 32'h0);

        // back-to-back loads, SB, then LW of the merged word
        preload(6'd12, 32'h0102_0304);
        issue(1'b0, 3'd2, 32'h30, 32'h0, 32'h0102_0304, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd4, 32'h31, 32'h0, 32'h0000_0003, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd0, 32'h32, 32'h0, 32'h0000_0002, 1'b0, 1, 1'b1, acc);
        issue(1'b0, 3'd5, 32'h32, 32'h0, 32'h0000_0102, 1'b0, 1, 1'b1, acc);
        issue(1'b1, 3'd0, 32'h30, 32'h0000_00EE, 32'h0, 1'b0, 2, 1'b1, acc_sb);
        issue(1'b0, 3'd2, 32'h30, 32'h0, 32'h0102_03EE, 1'b0, 1, 1'b1, acc);
        check("b2b_stall_cycles", acc - acc_sb, 2);
        drain();

        // reset during RMW_WR drops the pending write
        preload(6'd2, 32'h0000_0000);
        issue(1'b1, 3'd0, 32'h08, 32'h0000_00AB, 32'h0, 1'b0, 2, 1'b0, acc);
        check("rmw_write_strobe", {31'd0, dm_mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_dm_write", {31'd0, dm_mem_write}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_dm_word", dm_mem[2], 32'h0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1, 1'b1, acc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
